tp_buf_rd_ctrl: RTL and testbench
=================================

# tp_buf_rd_ctrl

Read-side buffer controller that sits between the transpose engine's read request port and the single-port feature-buffer SRAM. It accepts one line-read request per cycle and drives the SRAM access. It returns line data to the engine in request order with a fixed latency. Back-to-back reads of the same line are served from a held line register to save SRAM energy, and a pair of counters report request and SRAM-access statistics.

## Interface
Parameters:
- AW, 16, line address width
- BUFFD, 64, line width in bytes (data width BUFFD*8)
- RD_LAT, 2, SRAM read latency in cycles (≥1)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- init_pulse  in  1  one-cycle start-of-job; clears line-valid and counters
- raddr  in  AW  read line address from transpose engine
- raddr_vld  in  1  read request strobe, one request per cycle, no backpressure
- rdata  out  BUFFD*8  returned line data, held between returns
- rdata_vld  out  1  one-cycle strobe per returned request
- waddr  in  AW  write address snooped from engine write port
- wdata_vld  in  1  write strobe snooped from engine write port
- sram_ce  out  1  SRAM read enable
- sram_addr  out  AW  SRAM read address
- sram_rdata  in  BUFFD*8  SRAM read data
- req_cnt  out  CNT_W  requests accepted since init/reset
- acc_cnt  out  CNT_W  SRAM reads issued since init/reset

## Operation
- State: last_addr (AW), line_vld (1), delay pipe of RD_LAT+1 stages carrying {vld, hit}, rdata register, two counters.
- Hit = raddr_vld & line_vld & (raddr == last_addr) & ~(wdata_vld & waddr == raddr).
- Miss: sram_ce = raddr_vld & ~hit (combinational), sram_addr = raddr. On every accepted request: last_addr <= raddr, line_vld <= 1.
- Write snoop: wdata_vld & (waddr == last_addr) clears line_vld. If the same cycle also has a new read request, that read's update of last_addr/line_vld takes priority; a read to the written address that cycle is a miss.
- Output stage: a miss entry loads rdata <= sram_rdata. A hit entry leaves rdata unchanged. Because returns are in order, rdata then holds the previous fetch of the same line. rdata_vld = stage vld.
- init_pulse: line_vld <= 0, counters <= 0. The pipe is not flushed, so in-flight requests still return. A request in the same cycle as init_pulse is accepted and counted (counters read 1/1 afterwards), and it is always a miss.
- Counters: req_cnt += raddr_vld, acc_cnt += sram_ce. Both saturate at all-ones with no wrap.
- Invariant: acc_cnt ≤ req_cnt.

## Timing
- Request in cycle c, sram_ce in cycle c, sram_rdata valid in cycle c+RD_LAT (SRAM contract). rdata_vld/rdata are registered and appear in cycle c+RD_LAT+1.
- Latency is identical for hits and misses, so the output order always equals the request order.
- Throughput: one request per cycle sustained; no stalls.
- Reset values: rdata=0, rdata_vld=0, req_cnt=0, acc_cnt=0, line_vld=0, pipe cleared. sram_ce is 0 during reset (combinational but gated by reset).
- Reset mid-operation drops all in-flight returns; no rdata_vld after reset deasserts until a new request completes.

## Structure
- Package tp_rdc_pkg holds the RD_LAT default, CNT_W default, and the typedef of the pipe entry struct {logic vld; logic hit;}.
- Sub-module tp_rdc_pipe is a parameterised RD_LAT+1-deep shift register of pipe entries with async reset. The top handles hit detection, snoop, rdata register and counters.

## Test plan
- Single miss: RD_LAT=2, raddr=0x10 in cycle 0 → sram_ce=1, sram_addr=0x10 in cycle 0; rdata=SRAM line in cycle 3, rdata_vld one cycle; req_cnt=1, acc_cnt=1.
- Hit streak: raddr 0x20,0x20,0x20,0x21 back-to-back → sram_ce in cycles 0 and 3 only; four rdata_vld in cycles 3–6, first three carrying line 0x20; acc_cnt=2, req_cnt=4.
- Snoop invalidate: read 0x30, then write waddr=0x30, then read 0x30 → second read issues sram_ce; a write to 0x31 instead leaves the second read as a hit.
- Init boundary: read 0x40, init_pulse with read 0x40 in the same cycle → second read is a miss, both return, counters =1/1 after init.
- Saturation: preload counters near all-ones via a long stream (or use CNT_W=4) → both stop at 15 and do not wrap.
- Reset mid-flight: assert reset one cycle after a request → no rdata_vld ever for it; all outputs read zero.

Source files
------------

// File: rtl/tp_rdc_pkg.sv
// Shared defaults and pipe entry type for the transpose-engine read buffer controller.
package tp_rdc_pkg;
    localparam int RD_LAT_DEF = 2;
    localparam int CNT_W_DEF  = 32;

    typedef struct packed {
        logic vld;
        logic hit;
    } pipe_ent_t;
endpackage

// File: rtl/tp_rdc_pipe.sv
// DEPTH-stage shift register tracking in-flight reads; the second-to-last stage lines up
// with SRAM data, the last stage is the registered return strobe.
module tp_rdc_pipe
    import tp_rdc_pkg::*;
#(
    parameter int DEPTH = RD_LAT_DEF + 1
) (
    input  logic      clk,
    input  logic      rst,
    input  pipe_ent_t din,
    output pipe_ent_t tap,
    output logic      out_vld
);

    // The hit flag is dead once the entry has passed the rdata register, so the
    // final stage keeps only the valid bit.
    pipe_ent_t stage [DEPTH-1];
    logic      last_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stage[i] <= '0;
            end
            last_vld <= 1'b0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH - 1; i++) begin
                stage[i] <= stage[i-1];
            end
            last_vld <= stage[DEPTH-2].vld;
        end
    end

    assign tap     = stage[DEPTH-2];
    assign out_vld = last_vld;

endmodule

// File: rtl/tp_buf_rd_ctrl.sv
// Read-side feature-buffer controller: in-order fixed-latency returns, repeat reads of the
// held line skip the SRAM, write snoop invalidates the held line, saturating statistics.
module tp_buf_rd_ctrl
    import tp_rdc_pkg::*;
#(
    parameter int AW     = 16,
    parameter int BUFFD  = 64,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_pulse,
    input  logic [AW-1:0]      raddr,
    input  logic               raddr_vld,
    output logic [BUFFD*8-1:0] rdata,
    output logic               rdata_vld,
    input  logic [AW-1:0]      waddr,
    input  logic               wdata_vld,
    output logic               sram_ce,
    output logic [AW-1:0]      sram_addr,
    input  logic [BUFFD*8-1:0] sram_rdata,
    output logic [CNT_W-1:0]   req_cnt,
    output logic [CNT_W-1:0]   acc_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW-1:0] last_addr;
    logic          line_vld;
    logic          wr_to_rd;
    logic          hit;
    pipe_ent_t     pipe_in;
    pipe_ent_t     pipe_tap;

    assign wr_to_rd  = wdata_vld && (waddr == raddr);
    // A request coinciding with init is forced to fetch so a new job never reuses stale data.
    assign hit       = raddr_vld && line_vld && !init_pulse && (raddr == last_addr) && !wr_to_rd;
    assign sram_ce   = raddr_vld && !hit && !reset;
    assign sram_addr = raddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr <= '0;
            line_vld  <= 1'b0;
        end else if (raddr_vld) begin
            last_addr <= raddr;
            line_vld  <= 1'b1;
        end else if (init_pulse) begin
            line_vld  <= 1'b0;
        end else if (wdata_vld && (waddr == last_addr)) begin
            line_vld  <= 1'b0;
        end
    end

    assign pipe_in = '{vld: raddr_vld, hit: hit};

    tp_rdc_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_pipe (
        .clk     (clk),
        .rst     (reset),
        .din     (pipe_in),
        .tap     (pipe_tap),
        .out_vld (rdata_vld)
    );

    // Hits leave rdata alone: in-order returns mean it already holds that line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (pipe_tap.vld && !pipe_tap.hit) begin
            rdata <= sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt <= '0;
            acc_cnt <= '0;
        end else if (init_pulse) begin
            req_cnt <= CNT_W'(raddr_vld);
            acc_cnt <= CNT_W'(sram_ce);
        end else begin
            if (raddr_vld && (req_cnt != CNT_MAX)) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (sram_ce && (acc_cnt != CNT_MAX)) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tp_buf_rd_ctrl.sv
// Directed bench for tp_buf_rd_ctrl with a delayed-SRAM model and an in-order return scoreboard.
module tb_tp_buf_rd_ctrl;
    localparam int AW     = 16;
    localparam int BUFFD  = 4;
    localparam int DW     = BUFFD * 8;
    localparam int RD_LAT = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             init_pulse;
    logic [AW-1:0]    raddr;
    logic             raddr_vld;
    logic [DW-1:0]    rdata;
    logic             rdata_vld;
    logic [AW-1:0]    waddr;
    logic             wdata_vld;
    logic             sram_ce;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_rdata;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] acc_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    logic          sh_ce   [RD_LAT];
    logic [AW-1:0] sh_addr [RD_LAT];

    tp_buf_rd_ctrl #(
        .AW(AW), .BUFFD(BUFFD), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .init_pulse(init_pulse),
        .raddr(raddr), .raddr_vld(raddr_vld),
        .rdata(rdata), .rdata_vld(rdata_vld),
        .waddr(waddr), .wdata_vld(wdata_vld),
        .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .req_cnt(req_cnt), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // SRAM model: data only during the cycle the contract promises it, garbage otherwise.
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        sh_ce[0]   <= sram_ce;
        sh_addr[0] <= sram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            sh_ce[i]   <= sh_ce[i-1];
            sh_addr[i] <= sh_addr[i-1];
        end
    end

    always_comb begin
        sram_rdata = 32'hDEAD_BEEF;
        if (sh_ce[RD_LAT-1] === 1'b1) sram_rdata = line_data(sh_addr[RD_LAT-1]);
    end

    always @(posedge clk) begin
        #2;
        if (rdata_vld !== 1'b0) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_vld rdata_vld=%b cycle=%0d", rdata_vld, cyc_n);
            end else begin
                exp_t e;
                e = q.pop_front();
                assert (rdata === e.data && cyc_n == e.due) else begin
                    miscompares++;
                    $error("FAIL return got data=%h cycle=%0d exp data=%h cycle=%0d",
                           rdata, cyc_n, e.data, e.due);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; a read pushes its expected return and checks sram_ce/addr.
    task automatic step(input logic rv, input logic [AW-1:0] ra, input logic wv,
                        input logic [AW-1:0] wa, input logic ip, input logic exp_ce);
        raddr_vld  = rv;
        raddr      = ra;
        wdata_vld  = wv;
        waddr      = wa;
        init_pulse = ip;
        #1;
        if (rv) begin
            chk($sformatf("sram_ce@%h", ra), DW'(sram_ce), DW'(exp_ce));
            if (exp_ce) chk("sram_addr", DW'(sram_addr), DW'(ra));
            q.push_back('{data: line_data(ra), due: cyc_n + RD_LAT + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic exp_ce);
        step(1'b1, ra, 1'b0, '0, 1'b0, exp_ce);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic init_job();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic chk_cnt(input string tag, input int exp_req, input int exp_acc);
        chk({tag, "_req"}, DW'(req_cnt), DW'(exp_req));
        chk({tag, "_acc"}, DW'(acc_cnt), DW'(exp_acc));
    endtask

    initial begin
        reset = 1'b1; init_pulse = 1'b0; raddr = '0; raddr_vld = 1'b0;
        waddr = '0; wdata_vld = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin sh_ce[i] = 1'b0; sh_addr[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        raddr_vld = 1'b1; raddr = 16'h0099;
        #1;
        chk("reset_sram_ce", DW'(sram_ce), '0);
        chk("reset_rdata", rdata, '0);
        chk("reset_rdata_vld", DW'(rdata_vld), '0);
        chk_cnt("reset", 0, 0);
        raddr_vld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single miss
        rd(16'h0010, 1'b1);
        idle(4);
        chk_cnt("single", 1, 1);

        // hit streak
        init_job();
        rd(16'h0020, 1'b1);
        rd(16'h0020, 1'b0);
        rd(16'h0020, 1'b0);
        rd(16'h0021, 1'b1);
        idle(5);
        chk_cnt("streak", 4, 2);

        // snoop: write to held line invalidates, write elsewhere does not
        init_job();
        rd(16'h0030, 1'b1);
        step(1'b0, '0, 1'b1, 16'h0030, 1'b0, 1'b0);
        rd(16'h0030, 1'b1);
        step(1'b0, '0, 1'b1, 16'h0031, 1'b0, 1'b0);
        rd(16'h0030, 1'b0);
        // same-cycle read and write of one line: miss, then the read's update wins
        step(1'b1, 16'h0030, 1'b1, 16'h0030, 1'b0, 1'b1);
        rd(16'h0030, 1'b0);
        idle(5);
        chk_cnt("snoop", 5, 3);

        // init boundary: request riding on init is a miss and counts as 1/1
        rd(16'h0040, 1'b1);
        step(1'b1, 16'h0040, 1'b0, '0, 1'b1, 1'b1);
        idle(5);
        chk_cnt("init", 1, 1);

        // saturation, all misses then mostly hits
        init_job();
        for (int i = 0; i < 20; i++) rd(AW'(16'h0100 + i), 1'b1);
        idle(4);
        chk_cnt("sat_miss", 15, 15);
        init_job();
        rd(16'h0200, 1'b1);
        for (int i = 0; i < 19; i++) rd(16'h0200, 1'b0);
        idle(4);
        chk_cnt("sat_hit", 15, 1);

        // reset mid-flight: the in-flight request must never return
        rd(16'h0070, 1'b1);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_rdata", rdata, '0);
        chk("rst_rdata_vld", DW'(rdata_vld), '0);
        chk_cnt("rst", 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);
        rd(16'h0200, 1'b1);
        idle(5);
        chk_cnt("post_rst", 1, 1);

        chk("queue_drained", DW'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
